// File: rtl/pdp8_io_hub.sv
// pdp8_io_hub
//   IOT response merge, interrupt mask/priority controller and DMA RAM arbiter
//   for the PDP-8 I/O subsystem.
//
//   IOT side : iot/state/mb/io_select/io_data_in from the CPU.
//              dev_* per-slot responses come in, io_* registered responses go out.
//              The hub answers its own device code CTL_CODE. It has the lowest
//              priority, so any responding slot beats it.
//   Interrupt: io_interrupt = registered OR of (dev_interrupt & mask).
//   DMA side : dma_* per-port requests are arbitrated round-robin onto the
//              single io_ram_* port. dma_done pulses for one clk per transfer.
//              io_ram_in is broadcast to the devices outside this block.
module pdp8_io_hub #(
  parameter int          NDEV     = 4,
  parameter int          NDMA     = 2,
  parameter logic [5:0]  CTL_CODE = 6'o70
) (
  input  logic                 clk,
  input  logic                 reset,
  // CPU IOT interface
  input  logic                 iot,
  input  logic [3:0]           state,
  input  logic [11:0]          mb,
  input  logic [5:0]           io_select,
  input  logic [11:0]          io_data_in,
  // peripheral slots
  input  logic [NDEV-1:0]      dev_selected,
  input  logic [12*NDEV-1:0]   dev_data_out,
  input  logic [NDEV-1:0]      dev_data_avail,
  input  logic [NDEV-1:0]      dev_skip,
  input  logic [NDEV-1:0]      dev_clear_ac,
  input  logic [NDEV-1:0]      dev_interrupt,
  // merged response to CPU
  output logic [11:0]          io_data_out,
  output logic                 io_data_avail,
  output logic                 io_skip,
  output logic                 io_clear_ac,
  output logic                 io_interrupt,
  output logic                 io_conflict,
  // DMA ports
  input  logic [NDMA-1:0]      dma_read_req,
  input  logic [NDMA-1:0]      dma_write_req,
  input  logic [15*NDMA-1:0]   dma_ma,
  input  logic [12*NDMA-1:0]   dma_wdata,
  output logic [NDMA-1:0]      dma_done,
  // memory side
  output logic                 io_ram_read_req,
  output logic                 io_ram_write_req,
  output logic [14:0]          io_ram_ma,
  output logic [11:0]          io_ram_out,
  input  logic                 io_ram_done,
  input  logic [11:0]          io_ram_in
);

  typedef enum logic {DMA_IDLE, DMA_BUSY} dma_st_e;

  // CPU state is not decoded and RAM read data bypasses the hub.
  logic unused_ok;
  assign unused_ok = ^{state, mb[11:3], io_data_in, io_ram_in};

  logic [NDEV-1:0][11:0] dev_data;
  logic [NDMA-1:0][14:0] dma_ma_a;
  logic [NDMA-1:0][11:0] dma_wd_a;
  assign dev_data = dev_data_out;
  assign dma_ma_a = dma_ma;
  assign dma_wd_a = dma_wdata;

  // ---------------- state ----------------
  logic            iot_q;
  logic [NDEV-1:0] mask_q,      mask_d;
  logic [11:0]     data_q,      data_d;
  logic            avail_q,     avail_d;
  logic            skip_q,      skip_d;
  logic            clr_q,       clr_d;
  logic            intr_q,      intr_d;
  logic            conflict_q,  conflict_d;

  dma_st_e         dma_st_q,    dma_st_d;
  logic [1:0]      gnt_q,       gnt_d;
  logic [1:0]      ptr_q,       ptr_d;
  logic            rreq_q,      rreq_d;
  logic            wreq_q,      wreq_d;
  logic [14:0]     ram_ma_q,    ram_ma_d;
  logic [11:0]     ram_out_q,   ram_out_d;
  logic [NDMA-1:0] done_q,      done_d;

  // ---------------- interrupt priority ----------------
  logic            hub_sel, iot_edge;
  logic [NDEV-1:0] pend;
  logic            any_pend;
  logic [2:0]      pend_idx;

  assign hub_sel  = (io_select == CTL_CODE);
  assign iot_edge = iot & ~iot_q;
  assign pend     = dev_interrupt & mask_q;
  assign any_pend = |pend;

  // Downward scan so the lowest pending slot is the last (winning) assignment.
  always_comb begin
    pend_idx = 3'd0;
    for (int i = NDEV-1; i >= 0; i--)
      if (pend[i]) pend_idx = 3'(i);
  end

  // ---------------- IOT response merge ----------------
  always_comb begin
    data_d     = 12'o0;
    avail_d    = 1'b0;
    skip_d     = 1'b0;
    clr_d      = 1'b0;
    conflict_d = conflict_q;
    mask_d     = mask_q;
    intr_d     = any_pend;   // uses the pre-write mask, hence 2 clk mask latency

    if (iot) begin
      if ($countones({hub_sel, dev_selected}) > 1) conflict_d = 1'b1;

      if (dev_selected != '0) begin
        for (int i = NDEV-1; i >= 0; i--)
          if (dev_selected[i]) begin
            data_d  = dev_data[i];
            avail_d = dev_data_avail[i];
            skip_d  = dev_skip[i];
            clr_d   = dev_clear_ac[i];
          end
      end else if (hub_sel) begin
        if (iot_edge) begin
          skip_d = mb[0] & any_pend;
          if (mb[2]) begin
            avail_d = 1'b1;
            data_d  = any_pend ? {9'b0, pend_idx} : 12'o7777;
          end
        end else begin
          // Hub only acts on the IOT edge; later cycles replay that answer.
          data_d  = data_q;
          avail_d = avail_q;
          skip_d  = skip_q;
          clr_d   = clr_q;
        end
      end

      // Mask write happens even if a slot also claimed the cycle.
      if (hub_sel && iot_edge && mb[1]) mask_d = io_data_in[NDEV-1:0];
    end
  end

  // ---------------- DMA round-robin pick ----------------
  logic [NDMA-1:0] req_eff;
  logic            pick_found;
  logic [1:0]      pick_idx;
  logic [14:0]     pick_ma;
  logic [11:0]     pick_wd;
  logic            pick_wr;

  // A port still sees its request high during its dma_done cycle; ignore it
  // there so a finishing requester is not re-granted by accident.
  assign req_eff = (dma_read_req | dma_write_req) & ~done_q;

  // Pass 1 finds the lowest requester overall (the wrap-around case), pass 2
  // overrides it with the lowest requester at or after the pointer.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 2'd0;
    pick_ma    = 15'o0;
    pick_wd    = 12'o0;
    pick_wr    = 1'b0;
    for (int i = NDMA-1; i >= 0; i--)
      if (req_eff[i]) begin
        pick_found = 1'b1;
        pick_idx   = 2'(i);
        pick_ma    = dma_ma_a[i];
        pick_wd    = dma_wd_a[i];
        pick_wr    = dma_write_req[i];
      end
    for (int i = NDMA-1; i >= 0; i--)
      if (req_eff[i] && (i >= int'(ptr_q))) begin
        pick_idx   = 2'(i);
        pick_ma    = dma_ma_a[i];
        pick_wd    = dma_wd_a[i];
        pick_wr    = dma_write_req[i];
      end
  end

  always_comb begin
    dma_st_d  = dma_st_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    rreq_d    = rreq_q;
    wreq_d    = wreq_q;
    ram_ma_d  = ram_ma_q;
    ram_out_d = ram_out_q;
    done_d    = '0;
    case (dma_st_q)
      DMA_IDLE: if (pick_found) begin
        dma_st_d  = DMA_BUSY;
        gnt_d     = pick_idx;
        ram_ma_d  = pick_ma;
        ram_out_d = pick_wd;
        wreq_d    = pick_wr;      // read+write together is served as a write
        rreq_d    = ~pick_wr;
      end
      DMA_BUSY: if (io_ram_done) begin
        dma_st_d = DMA_IDLE;
        rreq_d   = 1'b0;
        wreq_d   = 1'b0;
        for (int i = 0; i < NDMA; i++)
          if (gnt_q == 2'(i)) done_d[i] = 1'b1;
        ptr_d = (gnt_q == 2'(NDMA-1)) ? 2'd0 : gnt_q + 2'd1;
      end
      default: dma_st_d = DMA_IDLE;
    endcase
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      iot_q      <= 1'b0;
      mask_q     <= '1;
      data_q     <= 12'o0;
      avail_q    <= 1'b0;
      skip_q     <= 1'b0;
      clr_q      <= 1'b0;
      intr_q     <= 1'b0;
      conflict_q <= 1'b0;
      dma_st_q   <= DMA_IDLE;
      gnt_q      <= 2'd0;
      ptr_q      <= 2'd0;
      rreq_q     <= 1'b0;
      wreq_q     <= 1'b0;
      ram_ma_q   <= 15'o0;
      ram_out_q  <= 12'o0;
      done_q     <= '0;
    end else begin
      iot_q      <= iot;
      mask_q     <= mask_d;
      data_q     <= data_d;
      avail_q    <= avail_d;
      skip_q     <= skip_d;
      clr_q      <= clr_d;
      intr_q     <= intr_d;
      conflict_q <= conflict_d;
      dma_st_q   <= dma_st_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      rreq_q     <= rreq_d;
      wreq_q     <= wreq_d;
      ram_ma_q   <= ram_ma_d;
      ram_out_q  <= ram_out_d;
      done_q     <= done_d;
    end
  end

  assign io_data_out      = data_q;
  assign io_data_avail    = avail_q;
  assign io_skip          = skip_q;
  assign io_clear_ac      = clr_q;
  assign io_interrupt     = intr_q;
  assign io_conflict      = conflict_q;
  assign dma_done         = done_q;
  assign io_ram_read_req  = rreq_q;
  assign io_ram_write_req = wreq_q;
  assign io_ram_ma        = ram_ma_q;
  assign io_ram_out       = ram_out_q;

endmodule

// File: tb/tb_pdp8_io_hub.sv
module tb_pdp8_io_hub;

  logic        clk = 1'b0;
  logic        reset, iot;
  logic [3:0]  state;
  logic [11:0] mb, io_data_in;
  logic [5:0]  io_select;
  logic [3:0]  dev_selected, dev_data_avail, dev_skip, dev_clear_ac, dev_interrupt;
  logic [47:0] dev_data_out;
  logic [11:0] io_data_out;
  logic        io_data_avail, io_skip, io_clear_ac, io_interrupt, io_conflict;
  logic [1:0]  dma_read_req, dma_write_req, dma_done;
  logic [29:0] dma_ma;
  logic [23:0] dma_wdata;
  logic        io_ram_read_req, io_ram_write_req, io_ram_done;
  logic [14:0] io_ram_ma;
  logic [11:0] io_ram_out, io_ram_in;

  int checks = 0;
  int errors = 0;
  logic mem_en = 1'b0;
  int   mem_cnt = 0;

  // expected {data, avail, skip, clear_ac, conflict, interrupt}
  logic [16:0] sb[$];

  typedef struct packed {
    logic iot; logic [5:0] sel; logic [2:0] p; logic [11:0] ac;
    logic [3:0] dsel; logic [3:0] dint;
    logic [11:0] d; logic a, s, c, k, i;
  } row_t;

  pdp8_io_hub #(.NDEV(4), .NDMA(2), .CTL_CODE(6'o70)) dut (
    .clk(clk), .reset(reset), .iot(iot), .state(state), .mb(mb),
    .io_select(io_select), .io_data_in(io_data_in),
    .dev_selected(dev_selected), .dev_data_out(dev_data_out),
    .dev_data_avail(dev_data_avail), .dev_skip(dev_skip),
    .dev_clear_ac(dev_clear_ac), .dev_interrupt(dev_interrupt),
    .io_data_out(io_data_out), .io_data_avail(io_data_avail), .io_skip(io_skip),
    .io_clear_ac(io_clear_ac), .io_interrupt(io_interrupt), .io_conflict(io_conflict),
    .dma_read_req(dma_read_req), .dma_write_req(dma_write_req), .dma_ma(dma_ma),
    .dma_wdata(dma_wdata), .dma_done(dma_done),
    .io_ram_read_req(io_ram_read_req), .io_ram_write_req(io_ram_write_req),
    .io_ram_ma(io_ram_ma), .io_ram_out(io_ram_out), .io_ram_done(io_ram_done),
    .io_ram_in(io_ram_in)
  );

  always #5 clk = ~clk;

  // Memory: answers io_ram_done on the third sampled clock of a request.
  always @(posedge clk) begin
    #1;
    if (mem_en && (io_ram_read_req || io_ram_write_req) && !io_ram_done) begin
      mem_cnt++;
      if (mem_cnt == 3) begin io_ram_done = 1'b1; mem_cnt = 0; end
    end else begin
      io_ram_done = 1'b0;
      mem_cnt = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [16:0] obs();
    return {io_data_out, io_data_avail, io_skip, io_clear_ac, io_conflict, io_interrupt};
  endfunction

  task automatic apply_row(input row_t r);
    iot = r.iot; io_select = r.sel; mb = {9'b0, r.p}; io_data_in = r.ac;
    dev_selected = r.dsel; dev_interrupt = r.dint;
    sb.push_back({r.d, r.a, r.s, r.c, r.k, r.i});
  endtask

  task automatic do_reset();
    reset = 1'b1; iot = 1'b0; dev_selected = '0; dev_interrupt = '0;
    dma_read_req = '0; dma_write_req = '0; mem_en = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; dev_interrupt = 4'b1000;
    step(); step();
    checks++;
    if ({obs(), dma_done, io_ram_read_req, io_ram_write_req, io_ram_ma, io_ram_out} !== 48'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", obs());
    end
    reset = 1'b0;
    step();
    checks++;
    if (io_interrupt !== 1'b1) begin
      errors++; $display("FAIL reset_mask_ones: got %b expected 1", io_interrupt);
    end
    dev_interrupt = '0;
    step();
  endtask

  task automatic test_iot_path();
    row_t t[$];
    logic [16:0] e;
    do_reset();
    t.push_back({1'b1, 6'o12, 3'd1, 12'o0, 4'b0100, 4'b0, 12'o1234, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    t.push_back({1'b1, 6'o12, 3'd1, 12'o0, 4'b0100, 4'b0, 12'o1234, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    t.push_back({1'b0, 6'o12, 3'd0, 12'o0, 4'b0000, 4'b0, 12'o0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    t.push_back({1'b1, 6'o13, 3'd2, 12'o0, 4'b1000, 4'b0, 12'o5555, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    t.push_back({1'b1, 6'o14, 3'd4, 12'o0, 4'b0000, 4'b0, 12'o0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    t.push_back({1'b0, 6'o14, 3'd0, 12'o0, 4'b0000, 4'b0, 12'o0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    for (int j = 0; j < t.size(); j++) begin
      apply_row(t[j]); step();
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL iot_path row %0d: got %h expected %h", j, obs(), e); end
    end
  endtask

  task automatic test_conflict();
    row_t t[$];
    logic [16:0] e;
    do_reset();
    t.push_back({1'b1, 6'o12, 3'd0, 12'o0, 4'b0110, 4'b0, 12'o0011, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    t.push_back({1'b0, 6'o12, 3'd0, 12'o0, 4'b0000, 4'b0, 12'o0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    t.push_back({1'b1, 6'o12, 3'd0, 12'o0, 4'b0001, 4'b0, 12'o7070, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    t.push_back({1'b0, 6'o12, 3'd0, 12'o0, 4'b0000, 4'b0, 12'o0,    1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    for (int j = 0; j < t.size(); j++) begin
      apply_row(t[j]); step();
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL conflict row %0d: got %h expected %h", j, obs(), e); end
    end
    do_reset();
    checks++;
    if (io_conflict !== 1'b0) begin errors++; $display("FAIL conflict_cleared: got %b expected 0", io_conflict); end
  endtask

  task automatic test_mask();
    row_t t[$];
    logic [16:0] e;
    do_reset();
    t.push_back({1'b1, 6'o70, 3'b010, 12'o0004, 4'b0, 4'b0101, 12'o0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    t.push_back({1'b0, 6'o70, 3'b000, 12'o0,    4'b0, 4'b0001, 12'o0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    t.push_back({1'b0, 6'o70, 3'b000, 12'o0,    4'b0, 4'b0101, 12'o0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    t.push_back({1'b1, 6'o70, 3'b010, 12'o0,    4'b0, 4'b0101, 12'o0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    t.push_back({1'b0, 6'o70, 3'b000, 12'o0,    4'b0, 4'b0101, 12'o0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    t.push_back({1'b1, 6'o70, 3'b010, 12'o7777, 4'b0, 4'b1000, 12'o0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    t.push_back({1'b0, 6'o70, 3'b000, 12'o0,    4'b0, 4'b1000, 12'o0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    for (int j = 0; j < t.size(); j++) begin
      apply_row(t[j]); step();
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL mask row %0d: got %h expected %h", j, obs(), e); end
    end
  endtask

  task automatic test_prio();
    row_t t[$];
    logic [16:0] e;
    do_reset();
    t.push_back({1'b1, 6'o70, 3'b100, 12'o0, 4'b0, 4'b1010, 12'o0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    t.push_back({1'b1, 6'o70, 3'b100, 12'o0, 4'b0, 4'b0000, 12'o0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    t.push_back({1'b0, 6'o70, 3'b000, 12'o0, 4'b0, 4'b0000, 12'o0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    t.push_back({1'b1, 6'o70, 3'b100, 12'o0, 4'b0, 4'b0000, 12'o7777, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    t.push_back({1'b0, 6'o70, 3'b000, 12'o0, 4'b0, 4'b0100, 12'o0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    t.push_back({1'b1, 6'o70, 3'b001, 12'o0, 4'b0, 4'b0100, 12'o0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    t.push_back({1'b0, 6'o70, 3'b000, 12'o0, 4'b0, 4'b0000, 12'o0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    t.push_back({1'b1, 6'o70, 3'b001, 12'o0, 4'b0, 4'b0000, 12'o0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    t.push_back({1'b0, 6'o70, 3'b000, 12'o0, 4'b0, 4'b1000, 12'o0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    t.push_back({1'b1, 6'o70, 3'b110, 12'o0, 4'b0, 4'b1000, 12'o0003, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
    t.push_back({1'b0, 6'o70, 3'b000, 12'o0, 4'b0, 4'b1000, 12'o0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    t.push_back({1'b1, 6'o70, 3'b100, 12'o0, 4'b0, 4'b1000, 12'o7777, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    t.push_back({1'b0, 6'o70, 3'b000, 12'o0, 4'b0, 4'b0000, 12'o0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    t.push_back({1'b1, 6'o70, 3'b100, 12'o0, 4'b0001, 4'b0, 12'o7070, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    for (int j = 0; j < t.size(); j++) begin
      apply_row(t[j]); step();
      e = sb.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL prio row %0d: got %h expected %h", j, obs(), e); end
    end
  endtask

  task automatic test_dma_rr();
    logic [28:0] gexp[$];
    int          gport[$];
    logic [28:0] e;
    logic        prev_req, prev_done;
    logic [1:0]  exp_done;
    int          last;
    do_reset();
    prev_req = 1'b0; prev_done = 1'b0; last = 0;
    dma_ma = {15'o02000, 15'o01000};
    dma_wdata = {12'o2222, 12'o1111};
    for (int k = 0; k < 4; k++) begin
      gport.push_back(k % 2);
      gexp.push_back((k % 2) == 0 ? {1'b0, 1'b1, 15'o01000, 12'o1111}
                                  : {1'b0, 1'b1, 15'o02000, 12'o2222});
    end
    mem_en = 1'b1;
    dma_write_req = 2'b11;
    for (int c = 0; c < 200 && gexp.size() > 0; c++) begin
      step();
      if ((io_ram_read_req || io_ram_write_req) && !prev_req) begin
        e = gexp.pop_front(); last = gport.pop_front(); checks++;
        if ({io_ram_read_req, io_ram_write_req, io_ram_ma, io_ram_out} !== e) begin
          errors++; $display("FAIL rr_grant port %0d: got %h expected %h", last,
                             {io_ram_read_req, io_ram_write_req, io_ram_ma, io_ram_out}, e);
        end
      end
      if (dma_done != 2'b00) begin
        exp_done = 2'b00; exp_done[last] = 1'b1; checks++;
        if (dma_done !== exp_done || prev_done) begin
          errors++; $display("FAIL rr_done: got %b (prev %b) expected %b single pulse", dma_done, prev_done, exp_done);
        end
      end
      prev_req  = io_ram_read_req || io_ram_write_req;
      prev_done = |dma_done;
    end
    checks++;
    if (gexp.size() != 0) begin errors++; $display("FAIL rr_timeout: got %0d grants left expected 0", gexp.size()); end
  endtask

  task automatic test_dma_reset();
    do_reset();
    dma_ma = {15'o00200, 15'o00100};
    dma_wdata = {12'o0202, 12'o0101};
    mem_en = 1'b1;
    dma_read_req = 2'b01; dma_write_req = 2'b01;
    for (int c = 0; c < 20 && !(io_ram_read_req || io_ram_write_req); c++) step();
    checks++;
    if ({io_ram_read_req, io_ram_write_req, io_ram_ma, io_ram_out} !== {1'b0, 1'b1, 15'o00100, 12'o0101}) begin
      errors++; $display("FAIL rw_as_write: got %b%b ma %o expected write ma 00100", io_ram_read_req, io_ram_write_req, io_ram_ma);
    end
    for (int c = 0; c < 20 && dma_done == 2'b00; c++) step();
    checks++;
    if (dma_done !== 2'b01) begin errors++; $display("FAIL port0_done: got %b expected 01", dma_done); end
    mem_en = 1'b0; dma_read_req = 2'b10; dma_write_req = 2'b00;
    for (int c = 0; c < 20 && !(io_ram_read_req || io_ram_write_req); c++) step();
    checks++;
    if ({io_ram_read_req, io_ram_write_req, io_ram_ma, io_ram_out} !== {1'b1, 1'b0, 15'o00200, 12'o0202}) begin
      errors++; $display("FAIL port1_read: got %b%b ma %o expected read ma 00200", io_ram_read_req, io_ram_write_req, io_ram_ma);
    end
    step(); step();
    reset = 1'b1;
    step();
    checks++;
    if ({io_ram_read_req, io_ram_write_req, dma_done} !== 4'b0000) begin
      errors++; $display("FAIL busy_reset: got req %b%b done %b expected 0", io_ram_read_req, io_ram_write_req, dma_done);
    end
    reset = 1'b0; dma_read_req = 2'b00; dma_write_req = 2'b11; mem_en = 1'b1;
    step();
    checks++;
    if ({dma_done, io_ram_read_req, io_ram_write_req, io_ram_ma, io_ram_out} !== {2'b00, 1'b0, 1'b1, 15'o00100, 12'o0101}) begin
      errors++; $display("FAIL post_reset_grant: got done %b ma %o expected port 0 ma 00100", dma_done, io_ram_ma);
    end
    do_reset();
  endtask

  initial begin
    reset = 1'b1; iot = 1'b0; state = 4'h0; mb = 12'o0; io_select = 6'o0; io_data_in = 12'o0;
    dev_selected = '0; dev_interrupt = '0;
    dev_data_out = {12'o5555, 12'o1234, 12'o0011, 12'o7070};
    dev_data_avail = 4'b1111; dev_skip = 4'b0100; dev_clear_ac = 4'b1000;
    dma_read_req = '0; dma_write_req = '0; dma_ma = '0; dma_wdata = '0;
    io_ram_done = 1'b0; io_ram_in = 12'o4321;
    test_reset();
    test_iot_path();
    test_conflict();
    test_mask();
    test_prio();
    test_dma_rr();
    test_dma_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pdp8_io_hub.md
Name: pdp8_io_hub

Overview:
Parametrised IOT response and DMA hub for the PDP-8 I/O subsystem.
- Merges response signals from NDEV peripheral slots into one registered IOT response to the CPU.
- Adds a software-visible interrupt mask and priority encoder, addressed as its own IOT device code.
- Arbitrates NDMA device RAM ports onto the single CPU-side io_ram port with round-robin grant.

Parameters:
NDEV, 4, number of peripheral slots (1..8); slot 0 has the highest interrupt priority.
NDMA, 2, number of DMA-capable RAM request ports (1..4).
CTL_CODE, 6'o70, IOT device code of the hub's own control register.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
iot  in  1  CPU IOT cycle strobe
state  in  4  CPU major state (passed through, not decoded)
mb  in  12  memory buffer; mb[2:0] = IOT pulse bits
io_select  in  6  IOT device code
io_data_in  in  12  AC value from CPU
dev_selected  in  NDEV  per-slot "decoded my code"
dev_data_out  in  12*NDEV  per-slot read data; slot k at [12k+11:12k]
dev_data_avail  in  NDEV  per-slot data valid
dev_skip  in  NDEV  per-slot skip
dev_clear_ac  in  NDEV  per-slot clear AC
dev_interrupt  in  NDEV  per-slot interrupt request (level)
io_data_out  out  12  registered IOT read data
io_data_avail  out  1  registered data valid
io_skip  out  1  registered skip
io_clear_ac  out  1  registered clear AC
io_interrupt  out  1  OR of masked requests (registered)
io_conflict  out  1  sticky: more than one responder in one IOT
dma_read_req  in  NDMA  per-port read request
dma_write_req  in  NDMA  per-port write request
dma_ma  in  15*NDMA  per-port address
dma_wdata  in  12*NDMA  per-port write data
dma_done  out  NDMA  per-port completion pulse
io_ram_read_req  out  1  to memory
io_ram_write_req  out  1  to memory
io_ram_ma  out  15  to memory
io_ram_out  out  12  write data to memory
io_ram_done  in  1  memory completion pulse
io_ram_in  in  12  read data; broadcast unchanged to all devices externally

Behaviour:
Reset values:
- All outputs 0.
- mask register = all ones (every slot enabled).
- DMA FSM = IDLE; round-robin pointer = 0.

IOT response path:
- Responders = dev_selected, plus the hub itself when io_select==CTL_CODE.
- Every cycle with iot=1, outputs are registered from the lowest-indexed responding slot; the hub has lowest priority.
- Latency is 1 clk. Outputs hold while iot stays 1.
- When iot=0, data/avail/skip/clear_ac register to 0 on the next clk.
- No responder: all response outputs 0.
- Two or more responders: lowest slot wins and io_conflict sets. io_conflict clears only on reset.

Hub control IOT (io_select==CTL_CODE, acted on in the first iot=1 cycle only; edge-detected on iot):
- mb[0]: skip if any masked request is pending.
- mb[1]: mask <= io_data_in[NDEV-1:0].
- mb[2]: io_data_out <= {9'b0, index of highest-priority masked pending slot}, io_data_avail=1. If none pending, return 12'o7777.
- Bits combine. When mb[1] and mb[2] are both set, the read uses the old mask.

Interrupt path:
- io_interrupt <= |(dev_interrupt & mask), registered with 1 clk latency.
- A mask write takes effect on io_interrupt 2 clks after the IOT edge.

DMA arbiter FSM:
- IDLE:
  - Requesting ports are those with read or write request set.
  - Pick the first requesting port at or after the pointer, wrapping modulo NDMA.
  - Latch its address, write data and direction, then go to BUSY.
  - A port asserting both read and write is served as a write.
- BUSY:
  - Drive io_ram_read_req or io_ram_write_req with latched ma/out.
  - On io_ram_done: drop the request, pulse dma_done[granted] for 1 clk, pointer <= granted+1 (wrap), go to IDLE.
- Requests are sampled only in IDLE. A port must hold its request until its dma_done.
- Minimum 1 idle clk between grants.
- A requester that drops its request while BUSY does not abort the transfer.
- Reset mid-transfer: return to IDLE, drop the RAM request, no dma_done.

Test Plan:
- Reset, then NDEV=4, dev_selected=4'b0100, dev_data_out slot2=12'o1234, skip=1, iot pulse -> 1 clk later io_data_out=12'o1234, io_skip=1, io_conflict=0; outputs 0 one clk after iot falls.
- dev_selected=4'b0110 with slot1 data 12'o0011 -> io_data_out=12'o0011, io_conflict=1 and stays 1 until reset.
- Mask write: IOT to 6'o70, mb[2:0]=3'b010, io_data_in=12'o0004, dev_interrupt=4'b0101 -> io_interrupt=1 (slot2); then write mask=0 -> io_interrupt=0 after 2 clks.
- Priority read: mask=4'b1111, dev_interrupt=4'b1010, IOT 6'o70 with mb=3'b100 -> io_data_out=12'o0001; with dev_interrupt=0 -> 12'o7777; mb=3'b001 with pending -> io_skip=1.
- DMA round-robin: ports 0 and 1 both request writes continuously, memory returns done 3 clks after each request -> grants alternate 0,1,0,1; io_ram_ma/io_ram_out match the granted port; each dma_done is a single-cycle pulse.
- Reset asserted during BUSY -> io_ram_write_req=0 next clk, no dma_done, pointer=0, next grant goes to port 0.
